pulse_param_bank: RTL and testbench

//  Double-buffered parameter bank directly upstream of PulseController; sole driver of its 16 duration inputs.

---
 rtl/pulse_param_bank.sv | 183 ++++++++++++++++++
 tb/tb_pulse_param_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_param_bank.sv
// Double-buffered duration bank feeding PulseController: host writes land in a shadow bank and are
// copied to the active bank atomically on commit. Optional readback port: define PULSE_PARAM_READBACK_EN.
module pulse_param_bank #(
  parameter logic [15:0] DEF_DUR            = 16'd100,
  parameter logic [15:0] MAX_DUR            = 16'hFFFF,
  parameter int          COMMIT_ON_BOUNDARY = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        commit_req,
  input  logic        seq_boundary,
  input  logic        sat_clr,
`ifdef PULSE_PARAM_READBACK_EN
  input  logic        rd_en,
  input  logic [3:0]  rd_addr,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_valid,
`endif
  output logic        commit_pending,
  output logic        commit_done,
  output logic        sat_flag,
  output logic [31:0] pos1dur,
  output logic [31:0] pos1pausedur,
  output logic [31:0] pos2dur,
  output logic [31:0] pos2pausedur,
  output logic [31:0] pos3dur,
  output logic [31:0] pos3pausedur,
  output logic [31:0] pos4dur,
  output logic [31:0] pos4pausedur,
  output logic [31:0] neg1dur,
  output logic [31:0] neg1pausedur,
  output logic [31:0] neg2dur,
  output logic [31:0] neg2pausedur,
  output logic [31:0] neg3dur,
  output logic [31:0] neg3pausedur,
  output logic [31:0] neg4dur,
  output logic [31:0] neg4pausedur
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        w_copy;
  logic        r_pending;
  logic        r_done;
  logic        r_sat;
  logic        w_sat_wr;
  logic [15:0] w_wr_val;
  logic [15:0] r_shadow [16];
  logic [15:0] r_active [16];

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > {16'd0, MAX_DUR}) ? MAX_DUR : v[15:0];
  endfunction

  assign w_wr_val = sat16(wr_data);
  assign w_sat_wr = wr_en && (wr_data > {16'd0, MAX_DUR});

  // Commit sequencing; w_copy marks the edge at which shadow is copied to active.
  always_comb begin
    w_state_nxt = r_state;
    w_copy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (commit_req) begin
          if ((COMMIT_ON_BOUNDARY != 0) && seq_boundary) begin
            w_copy      = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_PENDING;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if ((COMMIT_ON_BOUNDARY == 0) || seq_boundary) begin
          w_copy      = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_PENDING;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered status outputs decoded from the next state.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= (w_state_nxt == ST_PENDING);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  // Shadow/active banks: a copy takes the pre-write shadow, a same-cycle write lands in shadow only.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_shadow[i] <= DEF_DUR;
        r_active[i] <= DEF_DUR;
      end
    end else begin
      if (w_copy) begin
        for (int i = 0; i < 16; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (wr_en) begin
        r_shadow[wr_addr] <= w_wr_val;
      end
    end
  end

  // Sticky saturation flag; a saturating write beats a clear in the same cycle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if (w_sat_wr) begin
      r_sat <= 1'b1;
    end else if (sat_clr) begin
      r_sat <= 1'b0;
    end
  end

`ifdef PULSE_PARAM_READBACK_EN
  logic [31:0] r_rd_data;
  logic        r_rd_valid;

  // Registered readback of either bank; reads see the value before any same-cycle write.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_rd_data  <= 32'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= {16'd0, (rd_sel ? r_active[rd_addr] : r_shadow[rd_addr])};
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`else
  // Readback path not built.
`endif

  assign commit_pending = r_pending;
  assign commit_done    = r_done;
  assign sat_flag       = r_sat;

  assign pos1dur      = {16'd0, r_active[0]};
  assign pos1pausedur = {16'd0, r_active[1]};
  assign pos2dur      = {16'd0, r_active[2]};
  assign pos2pausedur = {16'd0, r_active[3]};
  assign pos3dur      = {16'd0, r_active[4]};
  assign pos3pausedur = {16'd0, r_active[5]};
  assign pos4dur      = {16'd0, r_active[6]};
  assign pos4pausedur = {16'd0, r_active[7]};
  assign neg1dur      = {16'd0, r_active[8]};
  assign neg1pausedur = {16'd0, r_active[9]};
  assign neg2dur      = {16'd0, r_active[10]};
  assign neg2pausedur = {16'd0, r_active[11]};
  assign neg3dur      = {16'd0, r_active[12]};
  assign neg3pausedur = {16'd0, r_active[13]};
  assign neg4dur      = {16'd0, r_active[14]};
  assign neg4pausedur = {16'd0, r_active[15]};

endmodule

// File: tb/tb_pulse_param_bank.sv
// Self-checking bench for pulse_param_bank: two instances (boundary-commit and immediate-commit)
// share stimulus and are compared against an abstract bank model every cycle.
module tb_pulse_param_bank;

  logic        clk_in = 1'b0;
  logic        reset, wr_en, commit_req, seq_boundary, sat_clr;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        d_pend [2];
  logic        d_done [2];
  logic        d_sat  [2];
  logic [31:0] d_out  [2][16];

  int vectors = 0;
  int miscompares = 0;

  // model state, index 1 = commit on boundary, index 0 = commit immediately
  int unsigned m_sh [2][16];
  int unsigned m_ac [2][16];
  bit          m_pend [2];
  bit          m_done [2];
  bit          m_sat;

  always #5 clk_in = ~clk_in;

  pulse_param_bank #(.COMMIT_ON_BOUNDARY(1)) u_dut1 (
    .clk_in(clk_in), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_req(commit_req), .seq_boundary(seq_boundary), .sat_clr(sat_clr),
    .commit_pending(d_pend[1]), .commit_done(d_done[1]), .sat_flag(d_sat[1]),
    .pos1dur(d_out[1][0]), .pos1pausedur(d_out[1][1]), .pos2dur(d_out[1][2]), .pos2pausedur(d_out[1][3]),
    .pos3dur(d_out[1][4]), .pos3pausedur(d_out[1][5]), .pos4dur(d_out[1][6]), .pos4pausedur(d_out[1][7]),
    .neg1dur(d_out[1][8]), .neg1pausedur(d_out[1][9]), .neg2dur(d_out[1][10]), .neg2pausedur(d_out[1][11]),
    .neg3dur(d_out[1][12]), .neg3pausedur(d_out[1][13]), .neg4dur(d_out[1][14]), .neg4pausedur(d_out[1][15])
  );

  pulse_param_bank #(.COMMIT_ON_BOUNDARY(0)) u_dut0 (
    .clk_in(clk_in), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_req(commit_req), .seq_boundary(seq_boundary), .sat_clr(sat_clr),
    .commit_pending(d_pend[0]), .commit_done(d_done[0]), .sat_flag(d_sat[0]),
    .pos1dur(d_out[0][0]), .pos1pausedur(d_out[0][1]), .pos2dur(d_out[0][2]), .pos2pausedur(d_out[0][3]),
    .pos3dur(d_out[0][4]), .pos3pausedur(d_out[0][5]), .pos4dur(d_out[0][6]), .pos4pausedur(d_out[0][7]),
    .neg1dur(d_out[0][8]), .neg1pausedur(d_out[0][9]), .neg2dur(d_out[0][10]), .neg2pausedur(d_out[0][11]),
    .neg3dur(d_out[0][12]), .neg3pausedur(d_out[0][13]), .neg4dur(d_out[0][14]), .neg4pausedur(d_out[0][15])
  );

  function automatic void model_edge(bit rst, bit we, int unsigned wa, int unsigned wd, bit cr, bit sb, bit sc);
    bit copy;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int a = 0; a < 16; a++) begin
          m_sh[m][a] = 100;
          m_ac[m][a] = 100;
        end
        m_pend[m] = 0;
        m_done[m] = 0;
      end
      m_sat = 0;
      return;
    end
    for (int m = 0; m < 2; m++) begin
      copy = 0;
      if (m_pend[m]) begin
        if (m == 0 || sb) begin
          copy = 1; m_pend[m] = 0; m_done[m] = 1;
        end
      end else if (m_done[m]) begin
        m_done[m] = 0;
      end else if (cr) begin
        if (m == 1 && sb) begin
          copy = 1; m_done[m] = 1;
        end else begin
          m_pend[m] = 1;
        end
      end
      if (copy) m_ac[m] = m_sh[m];
      if (we) m_sh[m][wa] = (wd > 65535) ? 65535 : wd;
    end
    if (we && wd > 65535) m_sat = 1;
    else if (sc) m_sat = 0;
  endfunction

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      vectors++;
      assert (d_pend[m] === m_pend[m]) else begin
        miscompares++;
        $error("FAIL pending[cob=%0d] got %b expected %b", m, d_pend[m], m_pend[m]);
      end
      vectors++;
      assert (d_done[m] === m_done[m]) else begin
        miscompares++;
        $error("FAIL done[cob=%0d] got %b expected %b", m, d_done[m], m_done[m]);
      end
      vectors++;
      assert (d_sat[m] === m_sat) else begin
        miscompares++;
        $error("FAIL sat_flag[cob=%0d] got %b expected %b", m, d_sat[m], m_sat);
      end
      for (int a = 0; a < 16; a++) begin
        vectors++;
        assert (d_out[m][a] === m_ac[m][a]) else begin
          miscompares++;
          $error("FAIL active[cob=%0d][%0d] got %0d expected %0d", m, a, d_out[m][a], m_ac[m][a]);
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit we, input int unsigned wa, input int unsigned wd,
                      input bit cr, input bit sb, input bit sc);
    reset = rst; wr_en = we; wr_addr = wa[3:0]; wr_data = wd;
    commit_req = cr; seq_boundary = sb; sat_clr = sc;
    @(posedge clk_in);
    model_edge(rst, we, wa, wd, cr, sb, sc);
    #1;
    check_all();
  endtask

  task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0;
    commit_req = 1'b0; seq_boundary = 1'b0; sat_clr = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    expect_val("reset_pos1", d_out[1][0], 32'd100);
    expect_val("reset_neg4pause", d_out[1][15], 32'd100);

    // write 500 to pos2dur, commit, boundary 20 cycles later
    step(0, 1, 2, 500, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 19; i++) step(0, 0, 0, 0, 0, 0, 0);
    expect_val("pos2_before_boundary", d_out[1][2], 32'd100);
    expect_val("pending_held", {31'd0, d_pend[1]}, 32'd1);
    step(0, 0, 0, 0, 0, 1, 0);
    expect_val("pos2_after_boundary", d_out[1][2], 32'd500);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // saturation and sticky flag
    step(0, 1, 15, 32'h0001_2345, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 15, 32'h0001_0000, 0, 0, 1);
    step(0, 1, 14, 32'd65535, 0, 0, 0);
    expect_val("sat_flag_set_wins", {31'd0, d_sat[1]}, 32'd1);

    // write collides with the copy edge, then second commit via same-cycle req+boundary
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 7, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    expect_val("pos1_keeps_old", d_out[1][0], 32'd100);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    expect_val("pos1_second_commit", d_out[1][0], 32'd7);
    expect_val("neg4pause_saturated", d_out[1][15], 32'd65535);
    step(0, 0, 0, 0, 0, 0, 0);

    // reset while pending discards the commit
    step(0, 1, 5, 1234, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    expect_val("post_reset_pos3pause", d_out[1][5], 32'd100);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      int unsigned wd;
      wd = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 70000);
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 15), wd,
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
